// File: rtl/hall_call_dispatcher_if.sv
// Hall-call dispatcher bus: button panel in, car status in, offer handshake out.
interface hall_call_dispatcher_if #(
    parameter int NUM_ELEV   = 2,
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = 3
);
    logic                        call_valid;
    logic [FLOOR_W-1:0]          call_floor;
    logic                        call_dir;
    logic [NUM_ELEV*FLOOR_W-1:0] elev_floor;
    logic [NUM_ELEV-1:0]         elev_dir;
    logic [NUM_ELEV-1:0]         elev_idle;
    logic [NUM_ELEV-1:0]         assign_valid;
    logic [FLOOR_W-1:0]          assign_floor;
    logic                        assign_dir;
    logic [NUM_ELEV-1:0]         assign_ack;
    logic [NUM_FLOORS-1:0]       pending_up;
    logic [NUM_FLOORS-1:0]       pending_dn;
    logic                        busy;

    // dispatcher side
    modport master (
        input  call_valid, call_floor, call_dir, elev_floor, elev_dir, elev_idle, assign_ack,
        output assign_valid, assign_floor, assign_dir, pending_up, pending_dn, busy
    );

    // panel / car-controller side
    modport slave (
        output call_valid, call_floor, call_dir, elev_floor, elev_dir, elev_idle, assign_ack,
        input  assign_valid, assign_floor, assign_dir, pending_up, pending_dn, busy
    );
endinterface

// File: rtl/hall_call_dispatcher.sv
// Hall-call dispatcher: latches hallway presses, serves one pending call at a time
// (rotating fairness pointer), offers it to the cheapest car and retries the
// next-best car when an offer times out.
module hall_call_dispatcher #(
    parameter int NUM_ELEV    = 2,
    parameter int NUM_FLOORS  = 8,
    parameter int FLOOR_W     = 3,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    hall_call_dispatcher_if.master bus
);
    localparam int NSLOT  = 2 * NUM_FLOORS;
    localparam int SLOT_W = $clog2(NSLOT);
    localparam int COST_W = FLOOR_W + 2;
    localparam int CAR_W  = (NUM_ELEV > 1) ? $clog2(NUM_ELEV) : 1;
    localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, EVAL, OFFER} state_t;

    state_t                state, state_nxt;
    logic [NUM_FLOORS-1:0] pend_up, pend_dn, pend_up_nxt, pend_dn_nxt;
    logic [SLOT_W-1:0]     ptr, slot, sel_slot, slot_inc;
    logic [NUM_ELEV-1:0]   mask;
    logic [CAR_W-1:0]      car, best_car;
    logic [TO_W-1:0]       to_cnt;
    logic                  any_pend, best_found, acked, expired;
    logic                  slot_dir;
    logic [FLOOR_W-1:0]    slot_floor;
    logic [COST_W-1:0]     best_cost;
    logic [NUM_ELEV-1:0][COST_W-1:0] cost;

    // slot = dir*NUM_FLOORS + floor; upper half are up calls
    assign slot_dir   = (slot >= SLOT_W'(NUM_FLOORS));
    assign slot_floor = slot_dir ? FLOOR_W'(slot - SLOT_W'(NUM_FLOORS)) : FLOOR_W'(slot);
    assign slot_inc   = (slot == SLOT_W'(NSLOT - 1)) ? '0 : slot + 1'b1;
    assign acked      = (state == OFFER) && bus.assign_ack[car];
    assign expired    = (to_cnt == TO_W'(ACK_TIMEOUT - 1));

    // first pending slot at or after the pointer; descending scan so the nearest wins
    always_comb begin
        logic [NSLOT-1:0] slots;
        int idx;
        slots    = {pend_up, pend_dn};
        idx      = 0;
        any_pend = 1'b0;
        sel_slot = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NSLOT;
            if (slots[idx]) begin
                any_pend = 1'b1;
                sel_slot = SLOT_W'(idx);
            end
        end
    end

    // per-car cost: distance, plus a NUM_FLOORS penalty when the car is not a candidate
    for (genvar g = 0; g < NUM_ELEV; g++) begin : g_cost
        logic [FLOOR_W-1:0] ef;
        logic [FLOOR_W:0]   d;
        logic               approach, cand;
        assign ef       = bus.elev_floor[g*FLOOR_W +: FLOOR_W];
        assign d        = (ef > slot_floor) ? ({1'b0, ef} - {1'b0, slot_floor})
                                            : ({1'b0, slot_floor} - {1'b0, ef});
        assign approach = slot_dir ? (ef <= slot_floor) : (ef >= slot_floor);
        assign cand     = bus.elev_idle[g] | ((bus.elev_dir[g] == slot_dir) & approach);
        assign cost[g]  = cand ? COST_W'(d) : COST_W'(NUM_FLOORS) + COST_W'(d);
    end

    // cheapest non-excluded car; strict compare keeps the lowest index on ties
    always_comb begin
        best_found = 1'b0;
        best_car   = '0;
        best_cost  = '1;
        for (int i = 0; i < NUM_ELEV; i++) begin
            if (!mask[i] && (!best_found || cost[i] < best_cost)) begin
                best_found = 1'b1;
                best_car   = CAR_W'(i);
                best_cost  = cost[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state; ack takes priority over timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_pend) state_nxt = EVAL;
            EVAL:    state_nxt = best_found ? OFFER : IDLE;
            OFFER:   if (acked) state_nxt = IDLE;
                     else if (expired) state_nxt = EVAL;
            default: state_nxt = IDLE;
        endcase
    end

    // pending lamps: ack clears the served slot, a press on the same edge sets it again
    always_comb begin
        pend_up_nxt = pend_up;
        pend_dn_nxt = pend_dn;
        if (acked) begin
            if (slot_dir) pend_up_nxt[slot_floor] = 1'b0;
            else          pend_dn_nxt[slot_floor] = 1'b0;
        end
        if (bus.call_valid && ({1'b0, bus.call_floor} < (FLOOR_W+1)'(NUM_FLOORS))) begin
            if (bus.call_dir) pend_up_nxt[bus.call_floor] = 1'b1;
            else              pend_dn_nxt[bus.call_floor] = 1'b1;
        end
    end

    // pending registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_up <= '0;
            pend_dn <= '0;
        end else begin
            pend_up <= pend_up_nxt;
            pend_dn <= pend_dn_nxt;
        end
    end

    // dispatch datapath: selected slot, chosen car, exclusion mask, pointer, timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            slot   <= '0;
            car    <= '0;
            mask   <= '0;
            to_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (any_pend) slot <= sel_slot;
                EVAL: begin
                    to_cnt <= '0;
                    if (best_found) begin
                        car <= best_car;
                    end else begin
                        ptr  <= slot_inc;   // every car refused: move on, call stays pending
                        mask <= '0;
                    end
                end
                OFFER: begin
                    if (acked) begin
                        ptr    <= slot_inc;
                        mask   <= '0;
                        to_cnt <= '0;
                    end else if (expired) begin
                        mask[car] <= 1'b1;
                        to_cnt    <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.assign_valid = (state == OFFER) ? (NUM_ELEV'(1) << car) : '0;
    assign bus.assign_floor = (state == OFFER) ? slot_floor : '0;
    assign bus.assign_dir   = (state == OFFER) & slot_dir;
    assign bus.pending_up   = pend_up;
    assign bus.pending_dn   = pend_dn;
    assign bus.busy         = (state != IDLE);
endmodule
